pcie_tl_rx: RTL and testbench

Receive-side PCIe transaction layer: accepts 224-bit TLPs ({96-bit 3DW header, 128-bit payload}) from the data link layer, steers them by TC[0] into two virtual-channel FIFOs, round-robin arbitrates between the VCs, and replays each Memory Write TLP as a single-beat AXI write on a master AW/W/B port. All other TLP types are discarded. Each FIFO pop returns one flow-control credit for its VC. It is the inbound counterpart of the TL transmit path.

---
 rtl/pcie_tl_rx.sv | 208 ++++++++++++++++++++
 tb/tb_pcie_tl_rx.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_tl_rx.sv
// PCIe transaction-layer receive path: two per-VC TLP FIFOs, round-robin drain,
// Memory Write TLPs replayed as single-beat AXI writes, everything else dropped.
module pcie_tl_rx #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tlp_valid_i,
  input  logic [223:0]     tlp_i,
  output logic             tlp_ready_o,
  output logic [1:0]       fc_ret_o,
  output logic [31:0]      awaddr_o,
  output logic [7:0]       awlen_o,
  output logic [2:0]       awsize_o,
  output logic [1:0]       awburst_o,
  output logic             awvalid_o,
  input  logic             awready_i,
  output logic [127:0]     wdata_o,
  output logic [15:0]      wstrb_o,
  output logic             wlast_o,
  output logic             wvalid_o,
  input  logic             wready_i,
  input  logic [1:0]       bresp_i,
  input  logic             bvalid_i,
  output logic             bready_o,
  output logic [CNT_W-1:0] drop_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int unsigned TLP_W = 224;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_F = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    WAIT_B = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               last_q, last_d;
  logic               awvalid_q, awvalid_d;
  logic               wvalid_q, wvalid_d;
  logic               bready_q, bready_d;
  logic [31:0]        awaddr_q, awaddr_d;
  logic [127:0]       wdata_q, wdata_d;
  logic [15:0]        wstrb_q, wstrb_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic [CNT_W-1:0]   err_q, err_d;

  logic [1:0]             push;
  logic [1:0]             pop;
  logic [1:0]             full;
  logic [1:0]             nempty;
  logic [1:0][TLP_W-1:0]  head;
  logic                   accept;
  logic                   sel_c;
  logic [TLP_W-1:0]       pkt_c;
  logic                   pkt_ok_c;
  logic                   unused_hdr;

  // Ready depends only on pre-pop occupancy, never on the offered TLP.
  assign tlp_ready_o = ~|full;
  assign accept      = tlp_valid_i & tlp_ready_o;
  assign push        = {accept & tlp_i[212], accept & ~tlp_i[212]};

  for (genvar v = 0; v < 2; v++) begin : g_vc
    logic [TLP_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_F-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (push[v]) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop[v])  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        cnt_q <= cnt_q + CNT_F'(push[v]) - CNT_F'(pop[v]);
      end
    end

    always_ff @(posedge clk) begin
      if (push[v]) mem_q[wr_ptr_q] <= tlp_i;
    end

    assign head[v]   = mem_q[rd_ptr_q];
    assign full[v]   = (cnt_q == CNT_F'(FIFO_DEPTH));
    assign nempty[v] = (cnt_q != '0);
  end

  // Strobe for up to four DWs: first_be, 0xF in the middle, last_be at the end.
  function automatic logic [15:0] strb_f(input logic [9:0] len,
                                         input logic [3:0] fbe,
                                         input logic [3:0] lbe);
    logic [15:0] s;
    s = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (10'(i) < len) begin
        if (i == 0)                        s[4*i +: 4] = fbe;
        else if (10'(i) == len - 10'(1))   s[4*i +: 4] = lbe;
        else                               s[4*i +: 4] = 4'hF;
      end
    end
    return s;
  endfunction

  assign sel_c    = (nempty == 2'b11) ? ~last_q : nempty[1];
  assign pkt_c    = head[sel_c];
  assign pkt_ok_c = (pkt_c[223:221] == 3'b010) && (pkt_c[220:216] == 5'b00000) &&
                    (pkt_c[201:192] != 10'd0) && (pkt_c[201:192] <= 10'd4);
  assign unused_hdr = ^{pkt_c[215:202], pkt_c[191:168], pkt_c[129:128]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      drop_q    <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      drop_q    <= drop_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    drop_d    = drop_q;
    err_d     = err_q;
    pop       = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (|nempty) begin
          pop[sel_c] = 1'b1;
          last_d     = sel_c;
          if (pkt_ok_c) begin
            awaddr_d  = {pkt_c[159:130], 2'b00};
            wdata_d   = pkt_c[127:0];
            wstrb_d   = strb_f(pkt_c[201:192], pkt_c[163:160], pkt_c[167:164]);
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = SEND;
          end else if (drop_q != '1) begin
            drop_d = drop_q + CNT_W'(1);
          end
        end
      end
      SEND: begin
        // A dropped valid is the sticky "done" for that channel.
        if (awready_i) awvalid_d = 1'b0;
        if (wready_i)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WAIT_B;
        end
      end
      WAIT_B: begin
        if (bvalid_i) begin
          bready_d = 1'b0;
          state_d  = IDLE;
          if ((bresp_i != 2'b00) && (err_q != '1)) err_d = err_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign fc_ret_o   = pop;
  assign awaddr_o   = awaddr_q;
  assign awlen_o    = 8'd0;
  assign awsize_o   = 3'b100;
  assign awburst_o  = 2'b01;
  assign awvalid_o  = awvalid_q;
  assign wdata_o    = wdata_q;
  assign wstrb_o    = wstrb_q;
  assign wlast_o    = 1'b1;
  assign wvalid_o   = wvalid_q;
  assign bready_o   = bready_q;
  assign drop_cnt_o = drop_q;
  assign err_cnt_o  = err_q;

endmodule

// File: tb/tb_pcie_tl_rx.sv
// Directed and randomized bench for pcie_tl_rx with a per-VC queue reference model.
module tb_pcie_tl_rx;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0]  a;
    logic [127:0] d;
    logic [15:0]  s;
  } wr_t;

  logic         clk;
  logic         rst_n;
  logic         tlp_valid_i;
  logic [223:0] tlp_i;
  logic         tlp_ready_o;
  logic [1:0]   fc_ret_o;
  logic [31:0]  awaddr_o;
  logic [7:0]   awlen_o;
  logic [2:0]   awsize_o;
  logic [1:0]   awburst_o;
  logic         awvalid_o;
  logic         awready_i;
  logic [127:0] wdata_o;
  logic [15:0]  wstrb_o;
  logic         wlast_o;
  logic         wvalid_o;
  logic         wready_i;
  logic [1:0]   bresp_i;
  logic         bvalid_i;
  logic         bready_o;
  logic [15:0]  drop_cnt_o;
  logic [15:0]  err_cnt_o;

  pcie_tl_rx #(.FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .tlp_valid_i(tlp_valid_i), .tlp_i(tlp_i),
    .tlp_ready_o(tlp_ready_o), .fc_ret_o(fc_ret_o), .awaddr_o(awaddr_o),
    .awlen_o(awlen_o), .awsize_o(awsize_o), .awburst_o(awburst_o),
    .awvalid_o(awvalid_o), .awready_i(awready_i), .wdata_o(wdata_o),
    .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .drop_cnt_o(drop_cnt_o), .err_cnt_o(err_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  bit          aw_block = 1'b0;
  bit          rnd = 1'b0;
  logic [1:0]  bresp_sel = 2'b00;
  logic [31:0] got_aw[$];
  logic [143:0] got_w[$];
  wr_t         exp_q[$];
  wr_t         exp0[$];
  wr_t         exp1[$];
  int          fc0 = 0, fc1 = 0, b_hs = 0, err_seen = 0;
  int          b_exp = 0, exp_fc0 = 0, exp_fc1 = 0, exp_drop = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [223:0] mk(input logic [2:0] fmt, input logic [4:0] typ,
                                      input logic [2:0] tc, input logic [9:0] len,
                                      input logic [3:0] fbe, input logic [3:0] lbe,
                                      input logic [31:0] addr, input logic [127:0] pl);
    logic [223:0] t;
    t = '0;
    t[223:221] = fmt;
    t[220:216] = typ;
    t[214:212] = tc;
    t[201:192] = len;
    t[167:164] = lbe;
    t[163:160] = fbe;
    t[159:130] = addr[31:2];
    t[127:0]   = pl;
    return t;
  endfunction

  // Expected AXI beat: byte b belongs to DW b/4, enabled by that DW's byte-enable bit.
  function automatic wr_t expect_wr(input logic [9:0] len, input logic [3:0] fbe,
                                    input logic [3:0] lbe, input logic [31:0] addr,
                                    input logic [127:0] pl);
    wr_t w;
    logic [3:0] be;
    w.a = addr & 32'hFFFF_FFFC;
    w.d = pl;
    w.s = '0;
    for (int b = 0; b < 16; b++) begin
      if (b / 4 < int'(len)) begin
        if (b / 4 == 0) be = fbe;
        else if (b / 4 == int'(len) - 1) be = lbe;
        else be = 4'hF;
        w.s[b] = be[b % 4];
      end
    end
    return w;
  endfunction

  task automatic send(input logic [223:0] t);
    int  n;
    bit  rdy;
    bit  ok;
    n = 0;
    ok = 1'b0;
    tlp_i = t;
    tlp_valid_i = 1'b1;
    while (!ok && n < 300) begin
      @(negedge clk);
      rdy = tlp_ready_o;
      @(posedge clk);
      #1;
      n++;
      if (rdy) ok = 1'b1;
    end
    tlp_valid_i = 1'b0;
    chk("send_accept", 256'(ok), 256'(1));
    if (ok) begin
      if (t[212]) exp_fc1++;
      else exp_fc0++;
    end
  endtask

  task automatic mwr(input logic [2:0] tc, input logic [9:0] len, input logic [3:0] fbe,
                     input logic [3:0] lbe, input logic [31:0] addr, input logic [127:0] pl);
    exp_q.push_back(expect_wr(len, fbe, lbe, addr, pl));
    b_exp++;
    send(mk(3'b010, 5'b00000, tc, len, fbe, lbe, addr, pl));
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (b_hs < b_exp && t < 5000) begin
      @(posedge clk);
      t++;
    end
    step(2);
    chk(tag, 256'(t < 5000), 256'(1));
  endtask

  task automatic check_writes(input string tag);
    int n;
    n = exp_q.size();
    drain({tag, "_drain"});
    chk({tag, "_aw_count"}, 256'(got_aw.size()), 256'(n));
    chk({tag, "_w_count"}, 256'(got_w.size()), 256'(n));
    for (int i = 0; i < n; i++) begin
      if (i < got_aw.size() && i < got_w.size())
        chk({tag, "_write"}, 256'({got_aw[i], got_w[i]}), 256'(exp_q[i]));
    end
    exp_q.delete();
    got_aw.delete();
    got_w.delete();
  endtask

  // AXI slave: ready/valid either always-on, blocked, or random.
  initial begin
    awready_i = 1'b1; wready_i = 1'b1; bvalid_i = 1'b1; bresp_i = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      awready_i = aw_block ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      wready_i  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bvalid_i  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bresp_i   = rnd ? 2'($urandom_range(0, 3)) : bresp_sel;
    end
  end

  // Monitor: signals seen at the falling edge are what the next rising edge samples.
  always @(negedge clk) begin
    if (rst_n) begin
      if (awvalid_o && awready_i) got_aw.push_back(awaddr_o);
      if (wvalid_o && wready_i)   got_w.push_back({wdata_o, wstrb_o});
      if (bvalid_i && bready_o) begin
        b_hs++;
        if (bresp_i != 2'b00) err_seen++;
      end
      if (fc_ret_o[0]) fc0++;
      if (fc_ret_o[1]) fc1++;
    end
  end

  logic [223:0] bp[10];
  logic [223:0] t;
  wr_t          g;
  int           acc, cyc, snap0, snap1, k;
  bit           rdy, hit;
  logic [2:0]   r_fmt, r_tc;
  logic [4:0]   r_typ;
  logic [9:0]   r_len;
  logic [3:0]   r_fbe, r_lbe;
  logic [31:0]  r_addr;
  logic [127:0] r_pl;

  initial begin
    rst_n = 1'b0;
    tlp_valid_i = 1'b0;
    tlp_i = '0;
    step(3);
    chk("rst_tlp_ready", 256'(tlp_ready_o), 256'(1));
    chk("rst_fc_ret", 256'(fc_ret_o), 256'(0));
    chk("rst_valids", 256'({awvalid_o, wvalid_o, bready_o}), 256'(0));
    chk("rst_axi_fields", 256'({awaddr_o, wdata_o, wstrb_o}), 256'(0));
    chk("rst_counters", 256'({drop_cnt_o, err_cnt_o}), 256'(0));
    chk("axi_constants", 256'({awlen_o, awsize_o, awburst_o, wlast_o}),
        256'({8'd0, 3'b100, 2'b01, 1'b1}));
    rst_n = 1'b1;
    step(2);

    // Single MWr with cycle-exact latency.
    mwr(3'd0, 10'd4, 4'hF, 4'hF, 32'h1000_0010, 128'h0011_2233_4455_6677_8899_aabb_ccdd_0123);
    chk("single_fc_ret_pulse", 256'(fc_ret_o), 256'(2'b01));
    chk("single_awvalid_early", 256'(awvalid_o), 256'(0));
    step(1);
    chk("single_valids_n2", 256'({awvalid_o, wvalid_o}), 256'(2'b11));
    chk("single_fc_ret_end", 256'(fc_ret_o), 256'(0));
    chk("single_awaddr", 256'(awaddr_o), 256'(32'h1000_0010));
    chk("single_wstrb", 256'(wstrb_o), 256'(16'hFFFF));
    check_writes("single");

    // Partial strobes.
    mwr(3'd0, 10'd2, 4'h6, 4'h3, 32'h2000_0104, 128'hCAFE_F00D_0000_0000_1234_5678_9ABC_DEF0);
    mwr(3'd0, 10'd1, 4'h8, 4'hF, 32'h2000_0200, 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888);
    chk("partial_strb_len2", 256'(exp_q[0].s), 256'(16'h0036));
    chk("partial_strb_len1", 256'(exp_q[1].s), 256'(16'h0008));
    check_writes("partial");

    // Drops: MRd, MWr length 0, MWr length 5.
    send(mk(3'b000, 5'b00000, 3'd0, 10'd1, 4'hF, 4'h0, 32'h3000_0000, 128'h1));
    send(mk(3'b010, 5'b00000, 3'd0, 10'd0, 4'hF, 4'hF, 32'h3000_0010, 128'h2));
    send(mk(3'b010, 5'b00000, 3'd0, 10'd5, 4'hF, 4'hF, 32'h3000_0020, 128'h3));
    exp_drop += 3;
    step(10);
    chk("drop_no_axi", 256'(got_aw.size() + got_w.size()), 256'(0));
    chk("drop_cnt", 256'(drop_cnt_o), 256'(3));
    chk("drop_fc0", 256'(fc0), 256'(exp_fc0));

    // Backpressure: one write stuck in flight plus a full VC0 FIFO.
    aw_block = 1'b1;
    step(2);
    for (int i = 0; i < 10; i++) begin
      bp[i] = mk(3'b010, 5'b00000, 3'd0, 10'd4, 4'hF, 4'hF, 32'h4000_0000 + 32'(i * 16),
                 {96'h0, 32'(i + 100)});
      exp_q.push_back(expect_wr(10'd4, 4'hF, 4'hF, 32'h4000_0000 + 32'(i * 16),
                                {96'h0, 32'(i + 100)}));
      b_exp++;
    end
    acc = 0;
    cyc = 0;
    tlp_i = bp[0];
    tlp_valid_i = 1'b1;
    while (acc < 10 && cyc < 30) begin
      @(negedge clk);
      rdy = tlp_ready_o;
      @(posedge clk);
      #1;
      cyc++;
      if (rdy) begin
        acc++;
        exp_fc0++;
        if (acc < 10) tlp_i = bp[acc];
      end
    end
    tlp_valid_i = 1'b0;
    chk("bp_accepted", 256'(acc), 256'(DEPTH + 1));
    chk("bp_ready_low", 256'(tlp_ready_o), 256'(0));
    chk("bp_aw_hold", 256'({awvalid_o, awaddr_o}), 256'({1'b1, 32'h4000_0000}));
    aw_block = 1'b0;
    for (int i = acc; i < 10; i++) send(bp[i]);
    check_writes("bp");

    // Arbitration: VC1 blocker leaves the pointer at VC1, so VC0 goes next.
    aw_block = 1'b1;
    step(2);
    mwr(3'd1, 10'd1, 4'hF, 4'h0, 32'h5000_0000, 128'hB10C);
    mwr(3'd0, 10'd1, 4'hF, 4'h0, 32'h5000_0100, 128'hA0);
    mwr(3'd1, 10'd1, 4'hF, 4'h0, 32'h5000_0200, 128'hB0);
    mwr(3'd2, 10'd1, 4'hF, 4'h0, 32'h5000_0300, 128'hA1);
    mwr(3'd3, 10'd1, 4'hF, 4'h0, 32'h5000_0400, 128'hB1);
    aw_block = 1'b0;
    check_writes("arb");

    // Error response.
    bresp_sel = 2'b10;
    step(2);
    mwr(3'd0, 10'd3, 4'h1, 4'h8, 32'h6000_0040, 128'h5555_6666_7777_8888);
    check_writes("bresp");
    bresp_sel = 2'b00;
    step(2);
    chk("err_cnt", 256'(err_cnt_o), 256'(1));

    // Randomized traffic checked against per-VC ordering queues.
    rnd = 1'b1;
    step(2);
    for (int i = 0; i < 60; i++) begin
      r_fmt = 3'b010; r_typ = 5'b00000;
      r_tc = 3'($urandom_range(0, 7));
      r_len = 10'($urandom_range(1, 4));
      r_fbe = 4'($urandom); r_lbe = 4'($urandom);
      r_addr = $urandom;
      r_pl = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 9) < 3) begin
        k = $urandom_range(0, 3);
        case (k)
          0: r_fmt = 3'b000;
          1: r_typ = 5'($urandom_range(1, 31));
          2: r_len = 10'd0;
          default: r_len = 10'($urandom_range(5, 1023));
        endcase
        exp_drop++;
      end else begin
        b_exp++;
        if (r_tc[0]) exp1.push_back(expect_wr(r_len, r_fbe, r_lbe, r_addr, r_pl));
        else exp0.push_back(expect_wr(r_len, r_fbe, r_lbe, r_addr, r_pl));
      end
      send(mk(r_fmt, r_typ, r_tc, r_len, r_fbe, r_lbe, r_addr, r_pl));
      step($urandom_range(0, 2));
    end
    drain("rnd_drain");
    chk("rnd_count_match", 256'(got_aw.size() == got_w.size()), 256'(1));
    for (int i = 0; i < got_aw.size() && i < got_w.size(); i++) begin
      g = {got_aw[i], got_w[i]};
      hit = 1'b0;
      if (exp0.size() > 0 && exp0[0] == g) begin
        void'(exp0.pop_front());
        hit = 1'b1;
      end else if (exp1.size() > 0 && exp1[0] == g) begin
        void'(exp1.pop_front());
        hit = 1'b1;
      end
      chk("rnd_write_order", 256'(hit), 256'(1));
    end
    chk("rnd_leftover", 256'(exp0.size() + exp1.size()), 256'(0));
    chk("rnd_drop_cnt", 256'(drop_cnt_o), 256'(exp_drop));
    chk("rnd_err_cnt", 256'(err_cnt_o), 256'(err_seen));
    chk("rnd_fc", 256'({fc0, fc1}), 256'({exp_fc0, exp_fc1}));
    got_aw.delete();
    got_w.delete();
    rnd = 1'b0;

    // Asynchronous reset mid-transaction.
    aw_block = 1'b1;
    step(2);
    send(mk(3'b010, 5'b00000, 3'd0, 10'd1, 4'hF, 4'h0, 32'h7000_0000, 128'h77));
    send(mk(3'b010, 5'b00000, 3'd1, 10'd1, 4'hF, 4'h0, 32'h7000_0010, 128'h78));
    chk("rst_pre_awvalid", 256'(awvalid_o), 256'(1));
    snap0 = fc0;
    snap1 = fc1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valids", 256'({awvalid_o, wvalid_o, bready_o, fc_ret_o}), 256'(0));
    chk("rst_mid_ready", 256'(tlp_ready_o), 256'(1));
    chk("rst_mid_fields", 256'({awaddr_o, wdata_o, wstrb_o}), 256'(0));
    chk("rst_mid_counters", 256'({drop_cnt_o, err_cnt_o}), 256'(0));
    step(2);
    rst_n = 1'b1;
    aw_block = 1'b0;
    step(10);
    chk("rst_lost_writes", 256'(got_aw.size()), 256'(0));
    chk("rst_no_credits", 256'({fc0, fc1}), 256'({snap0, snap1}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
